// File: rtl/seq_multiplier_pkg.sv
// Shared function codes and FSM state encoding for the
// sequential shift-add multiplier and its neighbours.
package seq_multiplier_pkg;

    localparam logic [5:0] OP_ADD       = 6'b100000;
    localparam logic [5:0] OP_SUB       = 6'b100010;
    localparam logic [5:0] OP_AND       = 6'b100100;
    localparam logic [5:0] OP_OR        = 6'b100101;
    localparam logic [5:0] OP_SLT       = 6'b101010;
    localparam logic [5:0] OP_SRL       = 6'b000010;
    localparam logic [5:0] OP_MFHI      = 6'b010000;
    localparam logic [5:0] OP_MFLO      = 6'b010010;
    localparam logic [5:0] OP_MUL       = 6'b011001;
    localparam logic [5:0] OP_HILO_OPEN = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_datapath.sv
// Multiplicand latch, product register and the add/shift step.
// p_step is the product value one iteration ahead of p.
module mul_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p_step
);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH:0]     sum;

    // Carry is kept so the all-ones case does not truncate.
    always_comb begin
        sum    = {1'b0, p[2*WIDTH-1:WIDTH]}
               + (p[0] ? {1'b0, mcand} : '0);
        p_step = {sum, p[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            p     <= '0;
        end else if (load) begin
            mcand <= a;
            p     <= {{WIDTH{1'b0}}, b};
        end else if (step) begin
            p     <= p_step;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: edge-detected MUL start,
// WIDTH iterations, one-cycle done pulse with held product.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Signal,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               prev_mul;
    logic               is_mul;
    logic               start;
    logic               step;
    logic [2*WIDTH-1:0] p_step;

    assign is_mul = (Signal == OP_MUL);
    assign start  = is_mul && !prev_mul && (state == IDLE);
    assign step   = (state == RUN);

    mul_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (start),
        .step   (step),
        .a      (dataA),
        .b      (dataB),
        .p_step (p_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dataOut  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            counter  <= '0;
            prev_mul <= 1'b0;
        end else begin
            prev_mul <= is_mul;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST) begin
                        dataOut <= p_step;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
